// File: rtl/main_memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : main_memory_arbiter_if
// Description : Bundle of the fetch requester, data requester and memory
//               macro signals seen by main_memory_arbiter.
//               slave  - the arbiter's view (requests in, grants/returns out,
//                        memory strobes out, memory read data in)
//               master - the environment's view (requesters plus memory)
// Ports       : f_req/f_addr/f_flush -> f_gnt/f_rvalid/f_rdata (fetch)
//               d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata (data)
//               mem_addr/mem_wdata/mem_wen/mem_ren -> mem_rdata (memory)
//               stall_fetch (fetch waiting on a denied request)
// Revision    : 1.0 - initial release
// ============================================================================
interface main_memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // fetch requester
    logic                  f_req;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic                  f_flush;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [DATA_WIDTH-1:0] f_rdata;
    // data requester
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;
    // memory macro
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_wen;
    logic                  mem_ren;
    logic [DATA_WIDTH-1:0] mem_rdata;
    // pipeline stall
    logic                  stall_fetch;

    modport slave (
        input  f_req, f_addr, f_flush,
        output f_gnt, f_rvalid, f_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_wdata, mem_wen, mem_ren,
        input  mem_rdata,
        output stall_fetch
    );

    modport master (
        output f_req, f_addr, f_flush,
        input  f_gnt, f_rvalid, f_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_wdata, mem_wen, mem_ren,
        output mem_rdata,
        input  stall_fetch
    );
endinterface
`default_nettype wire

// File: rtl/main_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : main_memory_arbiter
// Description : Shares a single-ported main memory between instruction fetch
//               and the data stage. One access per cycle; data wins by
//               default, a saturating starvation counter forces a fetch grant
//               after STARVE_LIMIT consecutive denied fetch cycles. Read data
//               returns one cycle after the grant, steered by a registered
//               return tag; f_flush cancels an in-flight fetch return.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-low reset
//               bus  - main_memory_arbiter_if.slave (requesters + memory)
// Revision    : 1.0 - initial release
// ============================================================================
module main_memory_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    main_memory_arbiter_if.slave bus
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RT_NONE         = 2'd0,
        RT_FETCH        = 2'd1,
        RT_DATA         = 2'd2,
        RT_FETCH_KILLED = 2'd3
    } rtag_t;

    rtag_t                 r_tag;
    rtag_t                 w_tag_next;
    logic [3:0]            r_starve_cnt;
    logic [3:0]            w_starve_next;
    logic                  w_starved;
    logic                  w_f_gnt;
    logic                  w_d_gnt;
    logic                  w_f_rvalid;
    logic                  w_d_rvalid;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    // ------------------------------------------------------------------
    // Grant: fetch wins alone, or when it has been starved long enough.
    // d_gnt is the complement so at most one grant is ever asserted.
    // ------------------------------------------------------------------
    always_comb begin
        w_starved = (r_starve_cnt >= c_starve_limit);
        w_f_gnt   = bus.f_req & (~bus.d_req | w_starved);
        w_d_gnt   = bus.d_req & ~w_f_gnt;
    end

    // Consecutive-denial count; any cycle fetch is not waiting clears it.
    always_comb begin
        w_starve_next = 4'd0;
        if (bus.f_req && !w_f_gnt) begin
            w_starve_next = w_starved ? c_starve_limit : (r_starve_cnt + 4'd1);
        end
    end

    // Memory port driven by the winner; zeros on idle cycles.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_f_gnt) begin
            w_mem_addr = bus.f_addr;
        end else if (w_d_gnt) begin
            w_mem_addr = bus.d_addr;
            if (bus.d_we) begin
                w_mem_wdata = bus.d_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Return tag FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag        <= RT_NONE;
            r_starve_cnt <= 4'd0;
        end else begin
            r_tag        <= w_tag_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    // ------------------------------------------------------------------
    // Return tag FSM: next state and return decode.
    // A flush during an RT_FETCH return cycle suppresses that return at
    // once (behaves as RT_FETCH_KILLED); a flush together with a new fetch
    // grant records the new return as killed. The grant itself proceeds.
    // ------------------------------------------------------------------
    always_comb begin
        w_tag_next = RT_NONE;
        w_f_rvalid = 1'b0;
        w_d_rvalid = 1'b0;

        if (w_f_gnt) begin
            w_tag_next = bus.f_flush ? RT_FETCH_KILLED : RT_FETCH;
        end else if (w_d_gnt && !bus.d_we) begin
            w_tag_next = RT_DATA;
        end

        case (r_tag)
            RT_FETCH:        w_f_rvalid = ~bus.f_flush;
            RT_DATA:         w_d_rvalid = 1'b1;
            RT_FETCH_KILLED: w_f_rvalid = 1'b0;
            default:         w_f_rvalid = 1'b0;
        endcase
    end

    assign bus.f_gnt       = w_f_gnt;
    assign bus.d_gnt       = w_d_gnt;
    assign bus.stall_fetch = bus.f_req & ~w_f_gnt;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wdata   = w_mem_wdata;
    assign bus.mem_wen     = w_d_gnt & bus.d_we;
    assign bus.mem_ren     = w_f_gnt | (w_d_gnt & ~bus.d_we);
    assign bus.f_rvalid    = w_f_rvalid;
    assign bus.d_rvalid    = w_d_rvalid;
    assign bus.f_rdata     = w_f_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata     = w_d_rvalid ? bus.mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_main_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_memory_arbiter
// Description : Self-checking bench for main_memory_arbiter. A driver issues
//               directed and random traffic and pushes per-cycle expectations
//               and read-return data into queues; a monitor on the falling
//               edge pops and compares. Includes a 64-word memory macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    main_memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    main_memory_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 8) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | 32'(i * 7);
    endfunction

    // Memory macro: 1-cycle read latency, garbage on non-read cycles,
    // preloaded while reset is held.
    logic [DW-1:0] mem [0:63];
    logic [DW-1:0] mem_q;
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (bus.mem_wen) begin
            mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
        if (bus.mem_ren) mem_q <= mem[bus.mem_addr[5:0]];
        else             mem_q <= $urandom;
    end
    assign bus.mem_rdata = mem_q;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic          f_gnt;
        logic          d_gnt;
        logic          ren;
        logic          wen;
        logic          stall;
        logic          f_rv;
        logic          d_rv;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t          cyc_q[$];
    logic [DW-1:0] f_data_q[$];
    logic [DW-1:0] d_data_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("f_gnt",       64'(bus.f_gnt),       64'(e.f_gnt));
                check("d_gnt",       64'(bus.d_gnt),       64'(e.d_gnt));
                check("mem_ren",     64'(bus.mem_ren),     64'(e.ren));
                check("mem_wen",     64'(bus.mem_wen),     64'(e.wen));
                check("mem_addr",    64'(bus.mem_addr),    64'(e.addr));
                check("mem_wdata",   64'(bus.mem_wdata),   64'(e.wdata));
                check("stall_fetch", 64'(bus.stall_fetch), 64'(e.stall));
                check("f_rvalid",    64'(bus.f_rvalid),    64'(e.f_rv));
                check("d_rvalid",    64'(bus.d_rvalid),    64'(e.d_rv));
                if (bus.f_rvalid === 1'b1) begin
                    if (f_data_q.size() == 0) check("f_rdata_unexpected", 64'(1), 64'(0));
                    else check("f_rdata", 64'(bus.f_rdata), 64'(f_data_q.pop_front()));
                end else begin
                    check("f_rdata_masked", 64'(bus.f_rdata), 64'(0));
                end
                if (bus.d_rvalid === 1'b1) begin
                    if (d_data_q.size() == 0) check("d_rdata_unexpected", 64'(1), 64'(0));
                    else check("d_rdata", 64'(bus.d_rdata), 64'(d_data_q.pop_front()));
                end else begin
                    check("d_rdata_masked", 64'(bus.d_rdata), 64'(0));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model state (driver side)
    // ------------------------------------------------------------------
    int            denied = 0;       // consecutive cycles fetch waited
    logic          pend_f = 1'b0;
    logic          pend_d = 1'b0;
    logic [DW-1:0] pend_f_data = '0;
    logic [DW-1:0] pend_d_data = '0;
    logic [DW-1:0] ref_mem [0:63];
    logic          last_fgnt = 1'b0;
    logic          last_dgnt = 1'b0;

    // mode: 0 = normal, 1 = reset held low all cycle, 2 = reset pulse mid-cycle
    task automatic drive(input int mode,
                         input logic fr, input logic [AW-1:0] fa, input logic ff,
                         input logic dr, input logic dwe, input logic [AW-1:0] da,
                         input logic [DW-1:0] dwd);
        exp_t e;
        logic fw;
        logic dw;
        @(posedge clk);
        #1;
        rst = (mode == 1) ? 1'b0 : 1'b1;
        if (mode == 2) begin
            rst = 1'b0;
            #1;
            rst = 1'b1;
        end
        if (mode != 0) begin
            denied = 0; pend_f = 1'b0; pend_d = 1'b0;
        end
        bus.f_req = fr;  bus.f_addr = fa;  bus.f_flush = ff;
        bus.d_req = dr;  bus.d_we = dwe;   bus.d_addr = da;  bus.d_wdata = dwd;

        fw = fr && (!dr || denied >= SL);
        dw = dr && !fw;
        e.f_gnt = fw;
        e.d_gnt = dw;
        e.ren   = fw || (dw && !dwe);
        e.wen   = dw && dwe;
        e.addr  = fw ? fa : (dw ? da : '0);
        e.wdata = (dw && dwe) ? dwd : '0;
        e.stall = fr && !fw;
        e.f_rv  = pend_f && !ff;
        e.d_rv  = pend_d;
        if (e.f_rv) f_data_q.push_back(pend_f_data);
        if (e.d_rv) d_data_q.push_back(pend_d_data);
        cyc_q.push_back(e);

        if (fr && !fw) denied++;
        else           denied = 0;
        if (e.wen) ref_mem[da[5:0]] = dwd;
        pend_f      = fw && !ff;
        pend_f_data = ref_mem[fa[5:0]];
        pend_d      = dw && !dwe;
        pend_d_data = ref_mem[da[5:0]];
        if (mode == 1) begin
            denied = 0; pend_f = 1'b0; pend_d = 1'b0;
        end
        last_fgnt = fw;
        last_dgnt = dw;
    endtask

    task automatic idle();
        drive(0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Stimulus
    initial begin
        logic          f_r, d_r, d_w, fl;
        logic [AW-1:0] f_a, d_a;
        logic [DW-1:0] d_wd;
        f_r = 1'b0; d_r = 1'b0; d_w = 1'b0; fl = 1'b0;
        f_a = '0; d_a = '0; d_wd = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        bus.f_req = 1'b0; bus.f_addr = '0; bus.f_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset held with both requesting: no returns
        repeat (3) drive(1, 1'b1, 32'd8, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        // First fetch after release
        drive(0, 1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle();
        // Contention: data load wins, fetch next
        drive(0, 1'b1, 32'd12, 1'b0, 1'b1, 1'b0, 32'd3, 32'd0);
        drive(0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle();
        // Starvation under continuous stores
        for (int i = 0; i < 12; i++)
            drive(0, 1'b1, 32'd20, 1'b0, 1'b1, 1'b1, 32'(30 + i % 8), 32'(32'h1000 + i));
        idle();
        // Flush in return cycle, then flush coincident with grant
        drive(0, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(0, 1'b1, 32'd6, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        idle();
        // Store then load same address
        drive(0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd10, 32'h0000_1234);
        drive(0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd10, 32'd0);
        idle();
        // Async reset between grant and return, then counter restart check
        drive(0, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 6; i++)
            drive(0, 1'b1, 32'd9, 1'b0, 1'b1, 1'b1, 32'(40 + i), 32'(32'h2000 + i));
        idle();

        // Random traffic honouring the hold-until-granted rule
        for (int i = 0; i < 400; i++) begin
            if (!(f_r && !last_fgnt)) begin
                f_r = ($urandom_range(0, 3) != 0);
                f_a = 32'($urandom_range(0, 63));
            end
            if (!(d_r && !last_dgnt)) begin
                d_r  = ($urandom_range(0, 2) != 0);
                d_w  = ($urandom_range(0, 1) != 0);
                d_a  = 32'($urandom_range(0, 63));
                d_wd = $urandom;
            end
            fl = ($urandom_range(0, 9) == 0);
            drive(0, f_r, f_a, fl, d_r, d_w, d_a, d_wd);
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        check("cycle_queue_drained", 64'(cyc_q.size()), 64'(0));
        check("f_data_drained",      64'(f_data_q.size()), 64'(0));
        check("d_data_drained",      64'(d_data_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_memory_arbiter.md
# main_memory_arbiter

Shares the single-ported main memory between the fetch stage (instruction reads) and the memory stage (data loads/stores). The arbiter sits between both requesters and the memory macro and issues at most one memory access per cycle. Data accesses normally win, and a starvation counter guarantees fetch forward progress. Read data returns with a one-cycle registered tag, and a fetch flush cancels an in-flight instruction return after a taken jump.

## Interface
- ADDR_WIDTH, 32, address width of both requesters and memory
- DATA_WIDTH, 32, data width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (legal 1..15)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- f_req  in  1  fetch read request, held until f_gnt
- f_addr  in  ADDR_WIDTH  fetch address
- f_flush  in  1  cancel any fetch read already granted but not yet returned
- f_gnt  out  1  fetch request accepted this cycle (combinational)
- f_rvalid  out  1  f_rdata valid (registered)
- f_rdata  out  DATA_WIDTH  instruction word
- d_req  in  1  data request, held with stable fields until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid (registered, loads only)
- d_rdata  out  DATA_WIDTH  load data
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_wen  out  1  memory write strobe
- mem_ren  out  1  memory read strobe; mem_rdata valid next cycle
- mem_rdata  in  DATA_WIDTH  memory read data, 1-cycle latency
- stall_fetch  out  1  f_req & ~f_gnt, consumed by the stall logic

## Operation
- Grant, combinational each cycle:
  - Only one requester asserted: it wins.
  - Both asserted and starve_cnt < STARVE_LIMIT: data wins.
  - Both asserted and starve_cnt == STARVE_LIMIT: fetch wins.
- Exactly one of f_gnt / d_gnt is high when any request is present. Neither is high when none is.
- Winner drives mem_addr, plus mem_wdata/mem_wen for a data store, or mem_ren for any read. Idle cycle: mem_ren = mem_wen = 0, mem_addr/mem_wdata = 0.
- starve_cnt, width 4:
  - Increments, saturating at STARVE_LIMIT, when f_req & ~f_gnt.
  - Clears when f_gnt, or when f_req = 0.
- Return tag state machine, registered, one of:
  - RT_NONE
  - RT_FETCH
  - RT_DATA
  - RT_FETCH_KILLED
- Next tag after each cycle:
  - Fetch read granted → RT_FETCH.
  - Data load granted → RT_DATA.
  - Store or no grant → RT_NONE.
  - f_flush while in RT_FETCH → RT_FETCH_KILLED for the remainder of that cycle's return.
- Outputs by tag:
  - RT_FETCH: f_rvalid = 1, f_rdata = mem_rdata.
  - RT_DATA: d_rvalid = 1, d_rdata = mem_rdata.
  - RT_NONE / RT_FETCH_KILLED: both rvalid 0.
- Flush rules:
  - f_flush in the same cycle as a fetch grant makes the new return RT_FETCH_KILLED.
  - f_flush does not block the grant itself.
- f_rdata/d_rdata are 0 whenever their rvalid is 0 (masked).
- Stores complete at d_gnt. No response follows a store.

## Timing
- Reset (rst low, asynchronous): tag = RT_NONE, starve_cnt = 0. Therefore f_rvalid = d_rvalid = 0 and rdata = 0.
- Grant and memory-strobe outputs are combinational from inputs and are 0 while no request is asserted.
- Reset mid-access drops any pending return: the first cycle after release shows no rvalid.
- Read latency: grant in cycle N → rvalid in cycle N+1.
- Throughput: back-to-back grants allowed, one per cycle. The return of N overlaps the grant of N+1.
- Write latency: memory is written at the rising edge ending the grant cycle.
- Requesters must not change fields while req is high and gnt is low. Behaviour otherwise is undefined.
- Worst-case fetch wait under continuous data traffic: STARVE_LIMIT cycles denied, granted on cycle STARVE_LIMIT+1.

## Test plan
- Reset: hold rst low with f_req = d_req = 1 → f_rvalid = d_rvalid = 0. Release and preload mem[8] = 0xDEADBEEF; f_req with f_addr = 8 → f_gnt in cycle 0, f_rvalid with 0xDEADBEEF in cycle 1.
- Contention: f_req and d_req (load, addr 3) together → d_gnt first, d_rvalid next cycle. f_gnt follows in the following cycle once d_req drops.
- Starvation: d_req stores held continuously, f_req held, STARVE_LIMIT = 4 → f_gnt on the 5th cycle with d_gnt = 0 that cycle. Counter is 0 afterwards. stall_fetch is high for exactly the 4 preceding cycles.
- Flush: fetch read of addr 5 granted in cycle N, f_flush in cycle N+1 → f_rvalid = 0 in N+1, and the memory read still occurs. A flush coincident with a grant likewise kills that return.
- Store then load: d_we = 1, addr 10, wdata 0x1234 granted; next cycle load addr 10 → d_rvalid with 0x1234, and no rvalid for the store cycle.
- Async reset mid-read: assert rst low between the grant edge and the return edge → no rvalid after release. starve_cnt = 0, verified by fetch denied exactly STARVE_LIMIT cycles under continuous data traffic.
